// File: rtl/vga_pkg.sv
// vga_pkg: shared timing types for the VGA timing engine.
//   vga_axis_t   - active/front-porch/sync/back-porch lengths for one axis
//   vga_timing_t - horizontal and vertical axis timing
//   VGA_640x480  - standard 640x480@60 timing (25 MHz pixel rate)
//   total()      - full period of an axis (active + fp + sync + bp)
package vga_pkg;

    typedef struct packed {
        int active;
        int fp;
        int sync;
        int bp;
    } vga_axis_t;

    typedef struct packed {
        vga_axis_t h;
        vga_axis_t v;
    } vga_timing_t;

    localparam vga_timing_t VGA_640x480 = '{
        h: '{active: 640, fp: 16, sync: 96, bp: 48},
        v: '{active: 480, fp: 10, sync: 2,  bp: 33}
    };

    function automatic int total(vga_axis_t a);
        return a.active + a.fp + a.sync + a.bp;
    endfunction

endpackage

// File: rtl/vga_pix_ce_div.sv
// vga_pix_ce_div: pixel clock-enable generator.
//   clk     in  system clock
//   rst     in  synchronous reset, active-high
//   pix_ce  out one-clk pulse every CLK_DIV clks (constant 1 after reset when CLK_DIV=1)
// pix_ce is registered so it is 0 during reset; the first pulse arrives
// CLK_DIV-1 clks after release and is consumed on the CLK_DIV-th edge.
module vga_pix_ce_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    output logic pix_ce
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_q, div_d;
    logic          pix_ce_q, pix_ce_d;

    always_comb begin
        div_d    = (div_q == LAST) ? '0 : div_q + 1'b1;
        // Register the strobe for the divider value being entered.
        pix_ce_d = (div_d == LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q    <= '0;
            pix_ce_q <= 1'b0;
        end else begin
            div_q    <= div_d;
            pix_ce_q <= pix_ce_d;
        end
    end

    assign pix_ce = pix_ce_q;

endmodule

// File: rtl/vga_timing_engine.sv
// vga_timing_engine: parametrised VGA timing engine.
//   clk, rst            system clock, synchronous active-high reset
//   rgb_in              {r,g,b} for the coordinate on cuentaX/cuentaY
//   pix_ce              pixel advance strobe
//   cuentaX, cuentaY    current horizontal / vertical counts
//   frame_start         pix_ce tick that begins pixel (0,0)
//   H_SYNC, V_SYNC      registered syncs (polarity HS_POL / VS_POL)
//   SYNC_B              composite sync, tied 0
//   SYNC_BLANK          blank_n, 1 in active video
//   r, g, b             registered colour to the DAC
// Sync and colour are registered on pix_ce from the current counters, so the
// DAC pins lag the coordinate outputs by exactly one pixel tick.
// Build option: VGA_TEST_PATTERN_EN replaces rgb_in with 8 vertical colour bars.
// The sync pulse widths are H_SYNC_LEN/V_SYNC_LEN since H_SYNC/V_SYNC name the pins.
module vga_timing_engine
    import vga_pkg::*;
#(
    parameter int CLK_DIV    = 2,
    parameter int H_ACTIVE   = VGA_640x480.h.active,
    parameter int H_FP       = VGA_640x480.h.fp,
    parameter int H_SYNC_LEN = VGA_640x480.h.sync,
    parameter int H_BP       = VGA_640x480.h.bp,
    parameter int V_ACTIVE   = VGA_640x480.v.active,
    parameter int V_FP       = VGA_640x480.v.fp,
    parameter int V_SYNC_LEN = VGA_640x480.v.sync,
    parameter int V_BP       = VGA_640x480.v.bp,
    parameter bit HS_POL     = 1'b0,
    parameter bit VS_POL     = 1'b0,
    parameter int CW         = 10,
    parameter int COLOR_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3*COLOR_W-1:0] rgb_in,
    output logic                 pix_ce,
    output logic [CW-1:0]        cuentaX,
    output logic [CW-1:0]        cuentaY,
    output logic                 frame_start,
    output logic                 H_SYNC,
    output logic                 V_SYNC,
    output logic                 SYNC_B,
    output logic                 SYNC_BLANK,
    output logic [COLOR_W-1:0]   r,
    output logic [COLOR_W-1:0]   g,
    output logic [COLOR_W-1:0]   b
);

    localparam vga_timing_t TIM = '{
        h: '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC_LEN, bp: H_BP},
        v: '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC_LEN, bp: V_BP}
    };
    localparam int H_TOTAL = total(TIM.h);
    localparam int V_TOTAL = total(TIM.v);

    localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT   = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT   = CW'(V_ACTIVE);
    // Inclusive sync windows; an inclusive end avoids overflowing CW when bp=0.
    localparam logic [CW-1:0] HS_BEG  = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_LAST = CW'(H_ACTIVE + H_FP + H_SYNC_LEN - 1);
    localparam logic [CW-1:0] VS_BEG  = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_LAST = CW'(V_ACTIVE + V_FP + V_SYNC_LEN - 1);

    vga_pix_ce_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk    (clk),
        .rst    (rst),
        .pix_ce (pix_ce)
    );

    logic [CW-1:0]        x_q, x_d, y_q, y_d;
    logic                 hs_q, hs_d, vs_q, vs_d, blank_q, blank_d;
    logic [3*COLOR_W-1:0] rgb_q, rgb_d;
    logic [3*COLOR_W-1:0] pix;
    logic                 active, hs_win, vs_win;

    // Pixel source for the active area.
`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] bar_idx;
    always_comb begin
        bar_idx = 3'((32'(x_q) * 32'd8) / 32'(H_ACTIVE));
        pix     = {{COLOR_W{bar_idx[2]}}, {COLOR_W{bar_idx[1]}}, {COLOR_W{bar_idx[0]}}};
    end
`else
    assign pix = rgb_in;
`endif

    always_comb begin
        active = (x_q < H_ACT) && (y_q < V_ACT);
        hs_win = (x_q >= HS_BEG) && (x_q <= HS_LAST);
        vs_win = (y_q >= VS_BEG) && (y_q <= VS_LAST);

        x_d     = x_q;
        y_d     = y_q;
        hs_d    = hs_q;
        vs_d    = vs_q;
        blank_d = blank_q;
        rgb_d   = rgb_q;
        if (pix_ce) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                y_d = (y_q == V_LAST) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
            hs_d    = hs_win ? HS_POL : ~HS_POL;
            vs_d    = vs_win ? VS_POL : ~VS_POL;
            blank_d = active;
            rgb_d   = active ? pix : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q     <= '0;
            y_q     <= '0;
            hs_q    <= ~HS_POL;
            vs_q    <= ~VS_POL;
            blank_q <= 1'b0;
            rgb_q   <= '0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            blank_q <= blank_d;
            rgb_q   <= rgb_d;
        end
    end

    assign cuentaX     = x_q;
    assign cuentaY     = y_q;
    assign frame_start = pix_ce && (x_q == '0) && (y_q == '0);
    assign H_SYNC      = hs_q;
    assign V_SYNC      = vs_q;
    assign SYNC_B      = 1'b0;
    assign SYNC_BLANK  = blank_q;
    assign {r, g, b}   = rgb_q;

endmodule

// File: tb/tb_vga_timing_engine.sv
// Bench for vga_timing_engine: three instances (default 640x480 /2, tiny /1,
// odd-sized /3 with positive syncs). The reference derives counters from the
// number of clocks since reset release and the DAC outputs from the pixel
// consumed one tick earlier.
module tb_vga_timing_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst[3];
    logic [23:0] rgb_in[3];
    logic        pce[3], fs[3], hs[3], vs[3], syncb[3], blank[3];
    logic [9:0]  cx[3], cy[3];
    logic [7:0]  ro[3], go[3], bo[3];

    vga_timing_engine u_d0 (
        .clk(clk), .rst(rst[0]), .rgb_in(rgb_in[0]), .pix_ce(pce[0]),
        .cuentaX(cx[0]), .cuentaY(cy[0]), .frame_start(fs[0]), .H_SYNC(hs[0]),
        .V_SYNC(vs[0]), .SYNC_B(syncb[0]), .SYNC_BLANK(blank[0]),
        .r(ro[0]), .g(go[0]), .b(bo[0]));

    vga_timing_engine #(
        .CLK_DIV(1), .H_ACTIVE(8), .H_FP(1), .H_SYNC_LEN(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC_LEN(1), .V_BP(1)
    ) u_d1 (
        .clk(clk), .rst(rst[1]), .rgb_in(rgb_in[1]), .pix_ce(pce[1]),
        .cuentaX(cx[1]), .cuentaY(cy[1]), .frame_start(fs[1]), .H_SYNC(hs[1]),
        .V_SYNC(vs[1]), .SYNC_B(syncb[1]), .SYNC_BLANK(blank[1]),
        .r(ro[1]), .g(go[1]), .b(bo[1]));

    vga_timing_engine #(
        .CLK_DIV(3), .H_ACTIVE(20), .H_FP(2), .H_SYNC_LEN(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC_LEN(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) u_d2 (
        .clk(clk), .rst(rst[2]), .rgb_in(rgb_in[2]), .pix_ce(pce[2]),
        .cuentaX(cx[2]), .cuentaY(cy[2]), .frame_start(fs[2]), .H_SYNC(hs[2]),
        .V_SYNC(vs[2]), .SYNC_B(syncb[2]), .SYNC_BLANK(blank[2]),
        .r(ro[2]), .g(go[2]), .b(bo[2]));

    // Per-instance configuration mirrored for the reference model.
    int p_div[3] = '{2, 1, 3};
    int p_ha[3]  = '{640, 8, 20};
    int p_hfp[3] = '{16, 1, 2};
    int p_hs[3]  = '{96, 2, 3};
    int p_hbp[3] = '{48, 1, 2};
    int p_va[3]  = '{480, 4, 6};
    int p_vfp[3] = '{10, 1, 1};
    int p_vs[3]  = '{2, 1, 2};
    int p_vbp[3] = '{33, 1, 1};
    bit p_hpol[3] = '{1'b0, 1'b0, 1'b1};
    bit p_vpol[3] = '{1'b0, 1'b0, 1'b1};

    typedef struct packed {
        logic        pce;
        logic        fs;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        hs;
        logic        vs;
        logic        syncb;
        logic        blank;
        logic [23:0] rgb;
    } st_t;

    int   n_run  = 0;
    int   n_fail = 0;
    int   kc[3];        // clock edges since reset release
    st_t  out_e[3];     // expected registered DAC outputs
    bit   use_fixed = 1'b0;
    logic [23:0] fixed_val = 24'hFF8040;

    function automatic st_t observe(int id);
        st_t o;
        o = '{pce: pce[id], fs: fs[id], x: cx[id], y: cy[id], hs: hs[id], vs: vs[id],
              syncb: syncb[id], blank: blank[id], rgb: {ro[id], go[id], bo[id]}};
        return o;
    endfunction

    // Counters and strobes follow from the pixel ticks consumed so far.
    function automatic st_t expect_st(int id);
        st_t e;
        int d, k, t, ht, vt;
        d  = p_div[id];
        k  = kc[id];
        ht = p_ha[id] + p_hfp[id] + p_hs[id] + p_hbp[id];
        vt = p_va[id] + p_vfp[id] + p_vs[id] + p_vbp[id];
        t  = (d == 1) ? ((k > 0) ? k - 1 : 0) : k / d;
        e       = out_e[id];
        e.syncb = 1'b0;
        e.pce   = (k > 0) && (k % d == d - 1);
        e.x     = 10'(t % ht);
        e.y     = 10'((t / ht) % vt);
        e.fs    = e.pce && (e.x == 0) && (e.y == 0);
        return e;
    endfunction

    function automatic logic [23:0] bars(int id, int x);
        int bar;
        logic [2:0] bi;
        bar = (x * 8) / p_ha[id];
        bi  = 3'(bar);
        return {{8{bi[2]}}, {8{bi[1]}}, {8{bi[0]}}};
    endfunction

    // Called at a negedge; leaves the instance in reset state with rst released.
    task automatic do_reset(int id, int n);
        rst[id] = 1'b1;
        repeat (n) @(posedge clk);
        @(negedge clk);
        rst[id]   = 1'b0;
        kc[id]    = 0;
        out_e[id] = '{pce: 1'b0, fs: 1'b0, x: 10'd0, y: 10'd0, hs: ~p_hpol[id],
                      vs: ~p_vpol[id], syncb: 1'b0, blank: 1'b0, rgb: 24'd0};
    endtask

    // One clock: if a pixel is consumed, the DAC takes its decode next state.
    task automatic advance(int id);
        st_t e;
        int  x, y, hb, vb;
        bit  act;
        e = expect_st(id);
        if (e.pce) begin
            x   = int'(e.x);
            y   = int'(e.y);
            hb  = p_ha[id] + p_hfp[id];
            vb  = p_va[id] + p_vfp[id];
            act = (x < p_ha[id]) && (y < p_va[id]);
            out_e[id].hs    = (x >= hb && x < hb + p_hs[id]) ? p_hpol[id] : ~p_hpol[id];
            out_e[id].vs    = (y >= vb && y < vb + p_vs[id]) ? p_vpol[id] : ~p_vpol[id];
            out_e[id].blank = act;
`ifdef VGA_TEST_PATTERN_EN
            out_e[id].rgb   = act ? bars(id, x) : 24'd0;
`else
            out_e[id].rgb   = act ? rgb_in[id] : 24'd0;
`endif
        end
        @(posedge clk);
        kc[id]++;
        @(negedge clk);
        rgb_in[id] = use_fixed ? fixed_val : 24'($urandom());
    endtask

    task automatic test_reset();
        st_t got, exp;
        for (int id = 0; id < 3; id++) begin
            do_reset(id, 5);
            got = observe(id);
            exp = expect_st(id);
            n_run++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL reset id%0d got=%h exp=%h", id, got, exp);
            end
        end
    endtask

    task automatic test_line_timing();
        st_t got, exp;
        int  ncyc = 4810;
        int  ce_cnt = 0;
        do_reset(0, 5);
        for (int i = 0; i < ncyc; i++) begin
            got = observe(0);
            exp = expect_st(0);
            n_run++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL line_timing k=%0d got=%h exp=%h", kc[0], got, exp);
            end
            if (got.pce) ce_cnt++;
            advance(0);
        end
        n_run++;
        if (ce_cnt !== ncyc / 2) begin
            n_fail++;
            $display("FAIL pix_ce_rate got=%0d exp=%0d", ce_cnt, ncyc / 2);
        end
    endtask

    task automatic test_blank_rgb();
        st_t got, exp;
        use_fixed = 1'b1;
        rgb_in[0] = fixed_val;
        do_reset(0, 2);
        for (int i = 0; i < 1700; i++) begin
            got = observe(0);
            exp = expect_st(0);
            n_run++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL blank_rgb k=%0d got=%h exp=%h", kc[0], got, exp);
            end
            advance(0);
        end
        use_fixed = 1'b0;
    endtask

    task automatic test_mid_reset();
        st_t got, exp;
        do_reset(0, 3);
        while (!(expect_st(0).x == 10'd300 && expect_st(0).y == 10'd1)) advance(0);
        do_reset(0, 1);
        got = observe(0);
        n_run++;
        if (got.x !== 10'd0 || got.y !== 10'd0 || got.hs !== 1'b1 || got.rgb !== 24'd0
            || got.pce !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset got=%h", got);
        end
        for (int i = 0; i < 1700; i++) begin
            got = observe(0);
            exp = expect_st(0);
            n_run++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL mid_reset_restart k=%0d got=%h exp=%h", kc[0], got, exp);
            end
            advance(0);
        end
    endtask

    task automatic test_small_frame();
        st_t got, exp;
        int  last_fs = -1;
        int  n_fs = 0;
        do_reset(1, 2);
        for (int i = 0; i < 300; i++) begin
            got = observe(1);
            exp = expect_st(1);
            n_run++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL small_frame k=%0d got=%h exp=%h", kc[1], got, exp);
            end
            if (got.fs) begin
                n_fs++;
                if (last_fs >= 0) begin
                    n_run++;
                    if (i - last_fs !== 84) begin
                        n_fail++;
                        $display("FAIL frame_period got=%0d exp=84", i - last_fs);
                    end
                end
                last_fs = i;
            end
            advance(1);
        end
        n_run++;
        if (n_fs !== 4) begin
            n_fail++;
            $display("FAIL frame_count got=%0d exp=4", n_fs);
        end
    endtask

    task automatic test_div3_polarity();
        st_t got, exp;
        do_reset(2, 4);
        for (int i = 0; i < 1650; i++) begin
            got = observe(2);
            exp = expect_st(2);
            n_run++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL div3_polarity k=%0d got=%h exp=%h", kc[2], got, exp);
            end
            advance(2);
        end
    endtask

    task automatic test_back_to_back();
        st_t got, exp;
        int  len;
        for (int it = 0; it < 6; it++) begin
            do_reset(2, int'($urandom_range(1, 3)));
            len = int'($urandom_range(50, 500));
            for (int i = 0; i < len; i++) begin
                got = observe(2);
                exp = expect_st(2);
                n_run++;
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL back_to_back it=%0d k=%0d got=%h exp=%h", it, kc[2], got, exp);
                end
                advance(2);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst[i]    = 1'b1;
            rgb_in[i] = 24'd0;
            kc[i]     = 0;
            out_e[i]  = '0;
        end
        test_reset();
        test_line_timing();
        test_blank_rgb();
        test_mid_reset();
        test_small_frame();
        test_div3_polarity();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
